qkv_loader: RTL and testbench
=============================

QKV_LOADER -- requirements
Module: qkv_loader

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, element width; VECTOR_DEPTH, default 64, elements per vector; NUM_WORDS, default 32, vectors per matrix; ADDR_W, default 5, buffer address width.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 load_req  input  1  single-cycle request to begin loading Q, K, V.
REQ-006 in_valid  input  1  in_data holds a valid element.
REQ-007 in_data  input  DATA_WIDTH  streamed element.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 wren_qkv_ext  output  3  one-hot write enable: bit0 Q, bit1 K, bit2 V buffer.
REQ-010 address_ext  output  ADDR_W  buffer write address (vector index).
REQ-011 data_ext  output  DATA_WIDTH*VECTOR_DEPTH  packed vector; element 0 in bits [DATA_WIDTH-1:0].
REQ-012 start  output  1  one-cycle pulse to the attention layer after the last V write.
REQ-013 busy  output  1  high from load_req acceptance until start pulse inclusive.
REQ-014 done  output  1  sticky completion flag.

Function
REQ-015 SHALL implement FSM states IDLE, PACK, WRITE, KICK.
REQ-016 IDLE: load_req=1 -> PACK next cycle; clears done, element counter, vector counter, matrix select (Q).
REQ-017 PACK: in_ready=1; an element is accepted only when in_valid=1 and in_ready=1; accepted element stored at lane = element counter.
REQ-018 PACK: element counter increments per accepted element; on acceptance with counter = VECTOR_DEPTH-1, counter wraps to 0 and FSM -> WRITE.
REQ-019 WRITE: in_ready=0; wren_qkv_ext = one-hot of matrix select for exactly one cycle; address_ext = vector counter; data_ext = fully packed vector.
REQ-020 Write latency: wren asserted the cycle immediately after the 64th element is accepted.
REQ-021 After WRITE: vector counter increments; at NUM_WORDS-1 it wraps to 0 and matrix select advances Q->K->V; FSM -> PACK, unless V vector NUM_WORDS-1 was written, then -> KICK.
REQ-022 KICK: start=1 for one cycle; next cycle -> IDLE, busy=0, done=1.
REQ-023 done SHALL stay 1 until the next accepted load_req or reset.
REQ-024 wren_qkv_ext SHALL be 3'b000 in every state except WRITE; never more than one bit set.
REQ-025 load_req outside IDLE SHALL be ignored with no state change.
REQ-026 in_valid while in_ready=0 SHALL be ignored; element not consumed, counters unchanged.
REQ-027 in_valid gaps (stalls) in PACK SHALL not alter packed data or counters.
REQ-028 data_ext SHALL hold its last value outside WRITE; address_ext SHALL hold its last value outside WRITE.
REQ-029 Minimum load time, continuous in_valid: 3*NUM_WORDS*(VECTOR_DEPTH+1) cycles from PACK entry to KICK (6240 at defaults).

Reset
REQ-030 reset=1 at any clock edge SHALL force IDLE, in_ready=0, wren_qkv_ext=0, address_ext=0, data_ext=0, start=0, busy=0, done=0, all counters 0, matrix select Q.
REQ-031 reset mid-load SHALL abort with no further writes; a partially packed vector SHALL be discarded.
REQ-032 reset SHALL take priority over load_req and in_valid in the same cycle.

Verification
REQ-033 Full load, continuous stream of values 0..6143 -> 96 single-cycle writes; Q addr0 lanes 0..63 = 0..63; V addr31 lane63 = 6143; start pulses once; done=1.
REQ-034 Random in_valid gaps (50% duty) with same data -> identical write contents/order as REQ-033; wren never asserted in PACK.
REQ-035 load_req pulsed during PACK after 10 elements -> ignored; counters continue; exactly 96 writes total.
REQ-036 reset asserted after 40 elements of K vector 5 -> next cycle all outputs 0, IDLE; new load_req restarts at Q addr0 lane0.
REQ-037 in_valid=1 held during every WRITE cycle with data 16'hFFFF -> value not consumed; next lane0 receives the following presented element.
REQ-038 Boundary check: write of Q addr31 followed by K addr0 with wren 3'b001 then 3'b010; after V addr31, start rises exactly one cycle after its wren.

Source files
------------

// File: rtl/qkv_loader.sv
// Purpose : packs a streamed element sequence into full vectors and writes them, one per
//           cycle, into the Q, K and V buffers in that order, then kicks the attention layer.
// Latency : the buffer write is issued the cycle after the last element of a vector is
//           accepted; start pulses the cycle after the final V write.
// Backpr. : in_ready is high only while packing; it drops for the write cycle and outside a
//           load, so elements presented then are not consumed.
//
// Ports
//   clk, reset              : sole clock, synchronous active-high reset
//   load_req                : single-cycle request to begin a Q/K/V load (honoured in IDLE only)
//   in_valid/in_data        : element stream; in_ready is the accept qualifier
//   wren_qkv_ext            : one-hot buffer write enable (bit0 Q, bit1 K, bit2 V)
//   address_ext             : vector index being written (held between writes)
//   data_ext                : packed vector, element 0 in the low lane (held between writes)
//   start                   : one-cycle kick after the last V write
//   busy                    : load in progress, up to and including the start pulse
//   done                    : sticky completion flag, cleared by the next accepted load_req
module qkv_loader #(
   parameter int DATA_WIDTH   = 16,
   parameter int VECTOR_DEPTH = 64,
   parameter int NUM_WORDS    = 32,
   parameter int ADDR_W       = 5
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               load_req,
   input  logic                               in_valid,
   input  logic [DATA_WIDTH-1:0]              in_data,
   output logic                               in_ready,
   output logic [2:0]                         wren_qkv_ext,
   output logic [ADDR_W-1:0]                  address_ext,
   output logic [DATA_WIDTH*VECTOR_DEPTH-1:0] data_ext,
   output logic                               start,
   output logic                               busy,
   output logic                               done
);

   localparam int ELEM_W = (VECTOR_DEPTH > 1) ? $clog2(VECTOR_DEPTH) : 1;
   localparam int VEC_W  = DATA_WIDTH * VECTOR_DEPTH;

   localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(VECTOR_DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PACK  = 2'd1,
      S_WRITE = 2'd2,
      S_KICK  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SEL_Q = 2'd0,
      SEL_K = 2'd1,
      SEL_V = 2'd2
   } sel_t;

   state_t              state_q, state_d;
   sel_t                sel_q,   sel_d;
   logic [ELEM_W-1:0]   elem_q,  elem_d;
   logic [ADDR_W-1:0]   vec_q,   vec_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic                done_q,  done_d;
   // pack_q collects lanes while packing; data_q is the output copy, so that data_ext
   // stays frozen on the last written vector while the next one is being assembled.
   logic [VEC_W-1:0]    pack_q,  pack_d;
   logic [VEC_W-1:0]    data_q,  data_d;

   // ------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      elem_d       = elem_q;
      vec_d        = vec_q;
      addr_d       = addr_q;
      done_d       = done_q;
      pack_d       = pack_q;
      data_d       = data_q;
      in_ready     = 1'b0;
      wren_qkv_ext = 3'b000;
      start        = 1'b0;
      busy         = 1'b1;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (load_req) begin
               state_d = S_PACK;
               done_d  = 1'b0;
               elem_d  = '0;
               vec_d   = '0;
               sel_d   = SEL_Q;
            end
         end

         S_PACK: begin
            in_ready = 1'b1;
            if (in_valid) begin
               pack_d[int'(elem_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
               if (elem_q == ELEM_LAST) begin
                  // Vector complete: capture it (including the lane just arriving)
                  // together with its address for the write cycle that follows.
                  elem_d  = '0;
                  data_d  = pack_d;
                  addr_d  = vec_q;
                  state_d = S_WRITE;
               end else begin
                  elem_d = elem_q + 1'b1;
               end
            end
         end

         S_WRITE: begin
            case (sel_q)
               SEL_Q:   wren_qkv_ext = 3'b001;
               SEL_K:   wren_qkv_ext = 3'b010;
               SEL_V:   wren_qkv_ext = 3'b100;
               default: wren_qkv_ext = 3'b000;
            endcase
            state_d = S_PACK;
            if (vec_q == ADDR_LAST) begin
               vec_d = '0;
               case (sel_q)
                  SEL_Q:   sel_d = SEL_K;
                  SEL_K:   sel_d = SEL_V;
                  default: begin
                     // Last V vector written: the whole load is in the buffers.
                     sel_d   = SEL_Q;
                     state_d = S_KICK;
                  end
               endcase
            end else begin
               vec_d = vec_q + 1'b1;
            end
         end

         S_KICK: begin
            start   = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            busy    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sel_q   <= SEL_Q;
         elem_q  <= '0;
         vec_q   <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         pack_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         elem_q  <= elem_d;
         vec_q   <= vec_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         pack_q  <= pack_d;
         data_q  <= data_d;
      end
   end

   assign address_ext = addr_q;
   assign data_ext    = data_q;
   assign done        = done_q;

endmodule

// File: tb/tb_qkv_loader.sv
module tb_qkv_loader;

   localparam int DW = 16;
   localparam int VD = 64;
   localparam int NW = 32;
   localparam int AW = 5;
   localparam int NV = 3 * NW;
   localparam int NE = NV * VD;
   localparam int VW = DW * VD;

   logic           clk = 1'b0;
   logic           reset;
   logic           load_req;
   logic           in_valid;
   logic [DW-1:0]  in_data;
   logic           in_ready;
   logic [2:0]     wren_qkv_ext;
   logic [AW-1:0]  address_ext;
   logic [VW-1:0]  data_ext;
   logic           start;
   logic           busy;
   logic           done;

   always #5 clk = ~clk;

   qkv_loader #(
      .DATA_WIDTH  (DW),
      .VECTOR_DEPTH(VD),
      .NUM_WORDS   (NW),
      .ADDR_W      (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load_req    (load_req),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .wren_qkv_ext(wren_qkv_ext),
      .address_ext (address_ext),
      .data_ext    (data_ext),
      .start       (start),
      .busy        (busy),
      .done        (done)
   );

   // Scenario table: stimulus knobs plus the expected per-load results.
   typedef struct {
      int gap;         // percent chance of an in_valid bubble
      int ldreq_at;    // element count at which a stray load_req is pulsed (-1: none)
      bit ff;          // present 16'hFFFF with in_valid during write cycles
      bit rnd;         // random element values instead of 0..NE-1
      int exp_writes;
      int exp_cycles;  // PACK entry to start; 0 = not checked (stalled stream)
      bit exp_done;
   } scen_t;

   scen_t tbl[5];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // Reference model state (transaction level).
   int vals[NE];
   int sptr, acc, mw, start_cnt, pack_entry, start_cyc;
   bit active, done_exp, pend_wr, start_exp, prev_final;
   logic [AW-1:0] last_addr;
   logic [VW-1:0] last_data;

   // Driver knobs.
   int gap, ldreq_at;
   bit ff, drv_en, ldreq_fired, item;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Whole-vector compare reported through its first differing lane.
   task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      int j;
      j = 0;
      for (int i = VD - 1; i >= 0; i--)
         if (act[i*DW +: DW] !== exp[i*DW +: DW]) j = i;
      check(name, 64'(act[j*DW +: DW]), 64'(exp[j*DW +: DW]));
   endtask

   // Vector k of a load holds stream elements k*VD .. k*VD+VD-1, lane 0 first.
   function automatic logic [VW-1:0] exp_vec(input int k);
      logic [VW-1:0] v;
      for (int j = 0; j < VD; j++) v[j*DW +: DW] = DW'(vals[k*VD + j]);
      return v;
   endfunction

   // Vectors 0..NW-1 go to Q, next NW to K, last NW to V.
   function automatic logic [2:0] exp_onehot(input int k);
      return 3'b001 << (k / NW);
   endfunction

   task automatic tick();
      bit rdy_exp, hs, was_active;
      logic [2:0] ew;
      @(negedge clk);
      cyc++;
      check("busy", 64'(busy), 64'(active));
      check("done", 64'(done), 64'(done_exp));
      start_exp = prev_final;
      check("start", 64'(start), 64'(start_exp));
      rdy_exp = active && !pend_wr && !start_exp;
      check("in_ready", 64'(in_ready), 64'(rdy_exp));
      ew = pend_wr ? exp_onehot(mw) : 3'b000;
      check("wren", 64'(wren_qkv_ext), 64'(ew));
      prev_final = 1'b0;
      if (pend_wr) begin
         last_addr = AW'(mw % NW);
         last_data = exp_vec(mw);
         check("wr_addr", 64'(address_ext), 64'(last_addr));
         check_vec("wr_data", data_ext, last_data);
         mw++;
         prev_final = (mw == NV);
      end else begin
         check("addr_hold", 64'(address_ext), 64'(last_addr));
         check_vec("data_hold", data_ext, last_data);
      end
      if (start) begin
         start_cnt++;
         start_cyc = cyc;
      end
      hs = in_valid && item && rdy_exp && !reset;

      @(posedge clk);
      if (reset) begin
         active     = 1'b0;
         done_exp   = 1'b0;
         pend_wr    = 1'b0;
         prev_final = 1'b0;
         last_addr  = '0;
         last_data  = '0;
      end else begin
         was_active = active;
         pend_wr = 1'b0;
         if (hs) begin
            acc++;
            sptr++;
            pend_wr = (acc % VD == 0);
         end
         if (start_exp) begin
            active   = 1'b0;
            done_exp = 1'b1;
         end
         if (load_req && !was_active) begin
            active     = 1'b1;
            done_exp   = 1'b0;
            pack_entry = cyc + 1;
            acc        = 0;
            mw         = 0;
            sptr       = 0;
         end
      end

      #1;
      load_req = 1'b0;
      if (ldreq_at >= 0 && !ldreq_fired && active && acc == ldreq_at) begin
         load_req    = 1'b1;
         ldreq_fired = 1'b1;
      end
      if (ff && pend_wr) begin
         in_valid = 1'b1;
         in_data  = 16'hFFFF;
         item     = 1'b0;
      end else if (drv_en && sptr < NE && $urandom_range(99) >= gap) begin
         in_valid = 1'b1;
         in_data  = DW'(vals[sptr]);
         item     = 1'b1;
      end else begin
         in_valid = 1'b0;
         in_data  = DW'($urandom);
         item     = 1'b0;
      end
   endtask

   task automatic fill_vals(input bit rnd);
      for (int k = 0; k < NE; k++) vals[k] = rnd ? int'($urandom_range(16'hFFFF)) : k;
   endtask

   task automatic run_load(input scen_t s);
      fill_vals(s.rnd);
      gap         = s.gap;
      ldreq_at    = s.ldreq_at;
      ff          = s.ff;
      ldreq_fired = 1'b0;
      start_cnt   = 0;
      drv_en      = 1'b1;
      load_req    = 1'b1;
      tick();
      for (int c = 0; c < 30000 && start_cnt == 0; c++) tick();
      repeat (4) tick();
      check("writes", 64'(mw), 64'(s.exp_writes));
      check("start_pulses", 64'(start_cnt), 64'(1));
      if (s.exp_cycles != 0)
         check("load_cycles", 64'(start_cyc - pack_entry), 64'(s.exp_cycles));
      check("done_after", 64'(done), 64'(s.exp_done));
      drv_en   = 1'b0;
      gap      = 0;
      ldreq_at = -1;
      ff       = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      load_req  = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      last_data = '0;
      last_addr = '0;
      ldreq_at  = -1;

      //         gap ldreq ff rnd writes cycles done
      tbl[0] = '{0,  -1,   0, 0,  NV,    6240,  1};   // contiguous 0..6143
      tbl[1] = '{50, -1,   0, 0,  NV,    0,     1};   // 50% bubbles, same data
      tbl[2] = '{0,  10,   0, 1,  NV,    6240,  1};   // stray load_req mid-pack
      tbl[3] = '{0,  -1,   1, 1,  NV,    6240,  1};   // 0xFFFF offered in write cycles
      tbl[4] = '{30, 200,  1, 1,  NV,    0,     1};   // mixed

      repeat (3) tick();
      reset = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) begin
         run_load(tbl[i]);
         repeat (3) tick();
      end

      // Reset together with load_req while idle and done: reset wins.
      reset    = 1'b1;
      load_req = 1'b1;
      tick();
      reset = 1'b0;
      repeat (3) tick();

      // Abort after 40 elements of K vector 5, then restart from scratch.
      fill_vals(1'b0);
      drv_en   = 1'b1;
      load_req = 1'b1;
      tick();
      for (int c = 0; c < 8000 && acc < 2*NW*VD - NW*VD + 5*VD + 40; c++) tick();
      check("abort_point", 64'(acc), 64'(NW*VD + 5*VD + 40));
      check("abort_writes", 64'(mw), 64'(NW + 5));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_wren", 64'(wren_qkv_ext), 64'(0));
      check("rst_addr", 64'(address_ext), 64'(0));
      check("rst_data_lane0", 64'(data_ext[DW-1:0]), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      drv_en = 1'b0;
      repeat (3) tick();
      run_load(tbl[0]);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
